// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: prioritized hold/flush sequencer for the 5-stage RV32IM pipeline.
// Define MULDIV_STALL_EN to enable multi-cycle divide sequencing (DIVWAIT, DIV_START).
module pipeline_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_DESREG,
  input  logic        EX_MEMREAD,
  input  logic        EX_REDIRECT,
  input  logic        EX_DIV,
  output logic        PC_HOLD,
  output logic        IFID_HOLD,
  output logic        IDEX_HOLD,
  output logic        EXMEM_HOLD,
  output logic        MEMWB_HOLD,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_FLUSH,
  output logic        DIV_START,
  output logic [31:0] STALL_COUNT
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_DIVWAIT  = 1'b1;
  localparam logic [4:0] LP_CNT_INIT = 5'(DIV_CYCLES - 2);

  logic        w_load_use;
  logic        w_div_hold;
  logic        w_div_start;
  logic [31:0] r_stall_count;

  assign w_load_use = EX_MEMREAD && (EX_DESREG != '0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_DESREG)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_DESREG)));

`ifdef MULDIV_STALL_EN
  logic [0:0] r_state;
  logic [4:0] r_cnt;

  assign w_div_hold  = (r_state == ST_DIVWAIT) && (r_cnt != '0);
  assign w_div_start = (r_state == ST_RUN) && EX_DIV;

  // CNT keeps draining through freezes; only the state change waits for the freeze to end.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      if (r_cnt != '0)
        r_cnt <= r_cnt - 5'd1;
      if (!DMEM_BUSYWAIT) begin
        if (w_div_start) begin
          r_state <= ST_DIVWAIT;
          r_cnt   <= LP_CNT_INIT;
        end else if ((r_state == ST_DIVWAIT) && (r_cnt == '0)) begin
          r_state <= ST_RUN;
        end
      end
    end
  end
`else
  logic w_unused_div;
  assign w_unused_div = ^{EX_DIV, LP_CNT_INIT, ST_RUN, ST_DIVWAIT};
  assign w_div_hold   = 1'b0;
  assign w_div_start  = 1'b0;
`endif

  always_comb begin
    PC_HOLD     = 1'b0;
    IFID_HOLD   = 1'b0;
    IDEX_HOLD   = 1'b0;
    EXMEM_HOLD  = 1'b0;
    MEMWB_HOLD  = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    DIV_START   = 1'b0;
    if (RESET) begin
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      EXMEM_FLUSH = 1'b1;
    end else if (DMEM_BUSYWAIT) begin
      PC_HOLD    = 1'b1;
      IFID_HOLD  = 1'b1;
      IDEX_HOLD  = 1'b1;
      EXMEM_HOLD = 1'b1;
      MEMWB_HOLD = 1'b1;
    end else if (w_div_hold || w_div_start) begin
      PC_HOLD     = 1'b1;
      IFID_HOLD   = 1'b1;
      IDEX_HOLD   = 1'b1;
      EXMEM_FLUSH = 1'b1;
      DIV_START   = w_div_start;
    end else if (EX_REDIRECT) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (w_load_use) begin
      PC_HOLD    = 1'b1;
      IFID_HOLD  = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (IMEM_BUSYWAIT) begin
      PC_HOLD    = 1'b1;
      IFID_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r_stall_count <= '0;
    else if (PC_HOLD)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign STALL_COUNT = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl; divide rows expect
// stalls only when MULDIV_STALL_EN is defined.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, IMEM_BUSYWAIT, DMEM_BUSYWAIT;
  logic [4:0]  ID_RS1, ID_RS2, EX_DESREG;
  logic        ID_USES_RS1, ID_USES_RS2, EX_MEMREAD, EX_REDIRECT, EX_DIV;
  logic        PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD;
  logic        IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, DIV_START;
  logic [31:0] STALL_COUNT;

  pipeline_hazard_ctrl #(.DIV_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_DESREG(EX_DESREG), .EX_MEMREAD(EX_MEMREAD), .EX_REDIRECT(EX_REDIRECT), .EX_DIV(EX_DIV),
    .PC_HOLD(PC_HOLD), .IFID_HOLD(IFID_HOLD), .IDEX_HOLD(IDEX_HOLD), .EXMEM_HOLD(EXMEM_HOLD),
    .MEMWB_HOLD(MEMWB_HOLD), .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
    .EXMEM_FLUSH(EXMEM_FLUSH), .DIV_START(DIV_START), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  // {PC,IFID,IDEX,EXMEM,MEMWB holds, IFID,IDEX,EXMEM flushes, DIV_START}
  localparam logic [8:0] E_NONE   = 9'b00000_000_0;
  localparam logic [8:0] E_RESET  = 9'b00000_111_0;
  localparam logic [8:0] E_FREEZE = 9'b11111_000_0;
  localparam logic [8:0] E_REDIR  = 9'b00000_110_0;
  localparam logic [8:0] E_LU     = 9'b11000_010_0;
  localparam logic [8:0] E_IMISS  = 9'b10000_100_0;
`ifdef MULDIV_STALL_EN
  localparam logic [8:0] D_S = 9'b11100_001_1;
  localparam logic [8:0] D_H = 9'b11100_001_0;
`else
  localparam logic [8:0] D_S = E_NONE;
  localparam logic [8:0] D_H = E_NONE;
`endif

  typedef struct {
    logic       rst, imem, dmem, redir, mr, div, u1, u2;
    logic [4:0] desreg, rs1, rs2;
    logic [8:0] exp;
  } vec_t;

  logic [8:0]  sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sc_exp = '0;

  function automatic vec_t mk(input logic rst, imem, dmem, redir, mr, div,
                              input logic [4:0] desreg, rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [8:0] exp);
    vec_t v;
    v.rst = rst; v.imem = imem; v.dmem = dmem; v.redir = redir; v.mr = mr; v.div = div;
    v.desreg = desreg; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t idle(input logic div, input logic [8:0] exp);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, div, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, exp);
  endfunction

  function automatic logic [8:0] outs();
    return {PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD,
            IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, DIV_START};
  endfunction

  task automatic apply(input vec_t v);
    RESET = v.rst; IMEM_BUSYWAIT = v.imem; DMEM_BUSYWAIT = v.dmem; EX_REDIRECT = v.redir;
    EX_MEMREAD = v.mr; EX_DIV = v.div; EX_DESREG = v.desreg; ID_RS1 = v.rs1;
    ID_USES_RS1 = v.u1; ID_RS2 = v.rs2; ID_USES_RS2 = v.u2;
    sb_q.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RESET));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL reset[%0d] outs: got %b want %b", k, outs(), exp);
      end
      if (!t[k].rst) begin
        checks++;
        if (STALL_COUNT !== sc_exp) begin
          errors++;
          $display("FAIL reset[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
        end
      end
      @(posedge CLK); #1;
      sc_exp = t[k].rst ? '0 : sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_load_use();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 5, 1, E_LU));
    t.push_back(idle(0, E_NONE));
    t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, E_NONE));
    t.push_back(mk(0, 0, 0, 0, 1, 0, 7, 7, 0, 3, 1, E_NONE));
    t.push_back(mk(0, 0, 0, 0, 1, 0, 7, 7, 1, 3, 1, E_LU));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 7, 7, 1, 7, 1, E_NONE));
    t.push_back(mk(0, 1, 0, 0, 1, 0, 9, 0, 0, 9, 1, E_LU));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL load_use[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL load_use[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_redirect_imiss();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_REDIR));
    t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IMISS));
    t.push_back(idle(0, E_NONE));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 6, 6, 1, 0, 0, E_REDIR));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL redirect[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL redirect[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_priority();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(mk(0, 1, 1, 1, 1, 0, 4, 4, 1, 0, 0, E_FREEZE));
    t.push_back(mk(0, 0, 1, 1, 1, 0, 4, 4, 1, 0, 0, E_FREEZE));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 4, 4, 1, 0, 0, E_REDIR));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL priority[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL priority[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_divide();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, E_FREEZE));
    t.push_back(idle(1, D_S));
    for (int i = 0; i < 6; i++) t.push_back(idle(1, D_H));
    t.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, E_REDIR));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL divide[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL divide[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[$];
    logic [8:0] exp;
    for (int r = 0; r < 2; r++) begin
      t.push_back(idle(1, D_S));
      for (int i = 0; i < 6; i++) t.push_back(idle(1, D_H));
      t.push_back(idle(1, E_NONE));
    end
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL back_to_back[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_freeze_div();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(idle(1, D_S));
    t.push_back(idle(1, D_H));
    for (int i = 0; i < 10; i++)
      t.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, E_FREEZE));
    t.push_back(idle(1, E_NONE));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL freeze_div[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL freeze_div[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = sc_exp + 32'(exp[8]);
    end
  endtask

  task automatic test_reset_mid_div();
    vec_t t[$];
    logic [8:0] exp;
    t.push_back(idle(1, D_S));
    t.push_back(idle(1, D_H));
    t.push_back(idle(1, D_H));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RESET));
    t.push_back(idle(0, E_NONE));
    t.push_back(idle(0, E_NONE));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL reset_mid_div[%0d] outs: got %b want %b", k, outs(), exp);
      end
      checks++;
      if (STALL_COUNT !== sc_exp) begin
        errors++;
        $display("FAIL reset_mid_div[%0d] stall_count: got %0d want %0d", k, STALL_COUNT, sc_exp);
      end
      @(posedge CLK); #1;
      sc_exp = t[k].rst ? '0 : sc_exp + 32'(exp[8]);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_imiss();
    test_priority();
    test_divide();
    test_back_to_back();
    test_freeze_div();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
